// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: state encoding,
// {gt, eq, lt} result codes and the digit-count helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    // Number of DIGIT-wide digits in a WIDTH-wide operand.
    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit digit pair.
module digit_cmp #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             dgt,
    output logic             dlt
);

    assign dgt = (x > y);
    assign dlt = (x < y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// MSB-first digit-serial magnitude comparator with early exit and start/busy/done handshake.
// Define COMPARE_SIGNED_EN to compare operands as two's complement.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    output logic                              busy,
    output logic                              done,
    output logic                              gt,
    output logic                              eq,
    output logic                              lt,
    output logic [$clog2(WIDTH/DIGIT):0]      digits_used
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned UW   = $clog2(NDIG) + 1;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [IW-1:0]     index;
    logic [DIGIT-1:0]  cur_a;
    logic [DIGIT-1:0]  cur_b;
    logic              dgt;
    logic              dlt;

    // Select the digit under inspection; signed mode flips the sign bit in the MSB digit.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (index == IW'(k)) begin
                cur_a = a_q[k*DIGIT +: DIGIT];
                cur_b = b_q[k*DIGIT +: DIGIT];
            end
        end
`ifdef COMPARE_SIGNED_EN
        if (index == IW'(NDIG - 1)) begin
            cur_a[DIGIT-1] = ~cur_a[DIGIT-1];
            cur_b[DIGIT-1] = ~cur_b[DIGIT-1];
        end
`endif
    end

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .x   (cur_a),
        .y   (cur_b),
        .dgt (dgt),
        .dlt (dlt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            index        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            {gt, eq, lt} <= RES_NONE;
            digits_used  <= '0;
        end else begin
            case (state)
                SCAN: begin
                    digits_used <= digits_used + UW'(1);
                    if (dgt || dlt) begin
                        {gt, eq, lt} <= dgt ? RES_GT : RES_LT;
                        state        <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else if (index == '0) begin
                        {gt, eq, lt} <= RES_EQ;
                        state        <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        index <= index - IW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; results hold otherwise.
                    done <= 1'b0;
                    if (start) begin
                        a_q          <= a;
                        b_q          <= b;
                        index        <= IW'(NDIG - 1);
                        {gt, eq, lt} <= RES_NONE;
                        digits_used  <= '0;
                        state        <= SCAN;
                        busy         <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomised self-checking bench for seq_magnitude_comparator (WIDTH=8, DIGIT=2),
// honouring COMPARE_SIGNED_EN in its reference model.
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int UW    = $clog2(NDIG) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [UW-1:0]    digits_used;

    int checks = 0;
    int fails  = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .digits_used (digits_used)
    );

    always #5 clk = ~clk;

    // Reference: full-value compare plus position of the first differing digit from the top.
    function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  output logic [2:0] res, output int du);
        logic found;
`ifdef COMPARE_SIGNED_EN
        if ($signed(x) > $signed(y))      res = 3'b100;
        else if ($signed(x) < $signed(y)) res = 3'b001;
        else                              res = 3'b010;
`else
        if (x > y)      res = 3'b100;
        else if (x < y) res = 3'b001;
        else            res = 3'b010;
`endif
        du = NDIG;
        found = 1'b0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            if (!found && (x[k*DIGIT +: DIGIT] != y[k*DIGIT +: DIGIT])) begin
                du = NDIG - k;
                found = 1'b1;
            end
        end
    endfunction

    // One full transaction; optionally scrambles a/b after capture.
    task automatic run_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                           input logic scramble, input string name);
        logic [2:0] exp_res;
        int         exp_du;
        int         cycles;
        logic       seen;
        model(ta, tb_v, exp_res, exp_du);
        @(posedge clk); #1;
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin a = '1; b = '1; end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || {gt, eq, lt} !== 3'b000 || digits_used !== '0) begin
            fails++;
            $display("FAIL %s capture: busy=%b done=%b res=%b du=%0d, required busy=1 done=0 res=000 du=0",
                     name, busy, done, {gt, eq, lt}, digits_used);
        end
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < NDIG + 4) begin
            @(posedge clk); #1;
            cycles++;
            if (busy && done) begin
                checks++; fails++;
                $display("FAIL %s overlap: busy and done both high at cycle %0d", name, cycles);
            end
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || cycles != exp_du) begin
            fails++;
            $display("FAIL %s latency: done seen=%b after %0d cycles, required %0d", name, seen, cycles, exp_du);
        end
        checks++;
        if ({gt, eq, lt} !== exp_res || digits_used !== UW'(exp_du)) begin
            fails++;
            $display("FAIL %s result: a=%h b=%h gt/eq/lt=%b du=%0d, required %b du=%0d",
                     name, ta, tb_v, {gt, eq, lt}, digits_used, exp_res, exp_du);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {gt, eq, lt} !== exp_res || digits_used !== UW'(exp_du)) begin
            fails++;
            $display("FAIL %s hold: done=%b busy=%b res=%b du=%0d, required 0 0 %b %0d",
                     name, done, busy, {gt, eq, lt}, digits_used, exp_res, exp_du);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, gt, eq, lt} !== 5'b0 || digits_used !== '0) begin
            fails++;
            $display("FAIL reset: busy/done/gt/eq/lt=%b du=%0d, required 00000 0", {busy, done, gt, eq, lt}, digits_used);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0] sign_res;
        run_cmp(8'hA5, 8'h5A, 1'b0, "a5_5a");
        run_cmp(8'h3C, 8'h3C, 1'b0, "equal_3c");
        run_cmp(8'h12, 8'h13, 1'b0, "lt_12_13");
        run_cmp(8'h80, 8'h01, 1'b0, "sign_80_01");
`ifdef COMPARE_SIGNED_EN
        sign_res = 3'b001;
`else
        sign_res = 3'b100;
`endif
        checks++;
        if ({gt, eq, lt} !== sign_res || digits_used !== UW'(1)) begin
            fails++;
            $display("FAIL sign_const: res=%b du=%0d, required %b du=1", {gt, eq, lt}, digits_used, sign_res);
        end
    endtask

    task automatic test_isolation();
        run_cmp(8'h12, 8'h13, 1'b1, "isolation");
    endtask

    task automatic test_back_to_back();
        int cycles;
        logic seen;
        @(posedge clk); #1;
        a = 8'h3C; b = 8'h3C; start = 1'b1;
        @(posedge clk); #1;
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < NDIG + 4) begin
            @(posedge clk); #1;
            cycles++;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || cycles != NDIG || {gt, eq, lt} !== 3'b010 || digits_used !== UW'(NDIG)) begin
            fails++;
            $display("FAIL held_start: seen=%b cycles=%0d res=%b du=%0d, required 1 %0d 010 %0d",
                     seen, cycles, {gt, eq, lt}, digits_used, NDIG, NDIG);
        end
        // Start stays high in the DONE cycle with new operands.
        a = 8'h01; b = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || {gt, eq, lt} !== 3'b000) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b res=%b, required 1 0 000", busy, done, {gt, eq, lt});
        end
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < NDIG + 4) begin
            @(posedge clk); #1;
            cycles++;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || cycles != NDIG || {gt, eq, lt} !== 3'b100 || digits_used !== UW'(NDIG)) begin
            fails++;
            $display("FAIL b2b_result: seen=%b cycles=%0d res=%b du=%0d, required 1 %0d 100 %0d",
                     seen, cycles, {gt, eq, lt}, digits_used, NDIG, NDIG);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic any_done;
        @(posedge clk); #1;
        a = 8'h3C; b = 8'h3C; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, gt, eq, lt} !== 5'b0 || digits_used !== '0) begin
            fails++;
            $display("FAIL async_reset: busy/done/gt/eq/lt=%b du=%0d, required 00000 0", {busy, done, gt, eq, lt}, digits_used);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < NDIG + 2; i++) begin
            @(posedge clk); #1;
            if (done || busy) any_done = 1'b1;
        end
        checks++;
        if (any_done) begin
            fails++;
            $display("FAIL reset_abort: done/busy seen after aborted scan, required none");
        end
        run_cmp(8'hC3, 8'hC7, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ WIDTH'($urandom_range(1, 3));
                2:       rb = ra ^ WIDTH'($urandom_range(1, 15));
                default: rb = WIDTH'($urandom);
            endcase
            run_cmp(ra, rb, i[0], "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_isolation();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
